// File: rtl/tc_spi_pkg.sv
// Shared types and constants for the thermocouple SPI arbiter.
package tc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    XFER = 2'd2,
    HOLD = 2'd3
  } arb_state_t;

  localparam int SPI_FRAME_W        = 32;
  localparam int TC_HOLDOFF_DEFAULT = 16;
  localparam int WD_W               = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tc_spi_arbiter_if.sv
// Bundle between tc_spi_arbiter, its sensor requesters and the shared SPI master.
interface tc_spi_arbiter_if #(
  parameter int NREQ = 4
);
  import tc_spi_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        done;
  logic [SPI_FRAME_W-1:0] rx_data;
  logic                   spi_ena;
  logic                   spi_not_busy;
  logic [SPI_FRAME_W-1:0] spi_rx_data;
  logic [NREQ-1:0]        spi_cs_n;
  logic                   timeout_err;

  modport slave (
    input  req, spi_not_busy, spi_rx_data,
    output grant, done, rx_data, spi_ena, spi_cs_n, timeout_err
  );

  modport master (
    output req, spi_not_busy, spi_rx_data,
    input  grant, done, rx_data, spi_ena, spi_cs_n, timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from last+1.
module rr_pick
  import tc_spi_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);

  always_comb begin
    int          idx;
    logic [IW-1:0] sel;
    logic        found;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        win[sel] = 1'b1;
        win_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/tc_spi_arbiter.sv
// Round-robin owner of one SPI master shared by NREQ sensor readers, with post-frame holdoff.
// Optional watchdog abort of stuck frames: define TC_SPI_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin
// ARM   | spi_ena high, waiting for the master to go busy
// XFER  | master busy, waiting for it to return idle with the frame
// HOLD  | first cycle keeps grant/CS, then bus released for HOLDOFF cycles
module tc_spi_arbiter
  import tc_spi_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int HOLDOFF = TC_HOLDOFF_DEFAULT,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst,
  tc_spi_arbiter_if.slave  bus
);

  localparam int              IW        = idx_width(NREQ);
  localparam int              HW        = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [IW-1:0]   LAST_RST  = IW'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
    $error("tc_spi_arbiter: NREQ must be in 2..8");
  end
  if (HOLDOFF < 1) begin : g_chk_holdoff
    $error("tc_spi_arbiter: HOLDOFF must be at least 1");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_chk_timeout
    $error("tc_spi_arbiter: TIMEOUT must fit 16 bits and be nonzero");
  end

  arb_state_t             state_q, state_nxt;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic [IW-1:0]          last_q, last_d;
  logic [SPI_FRAME_W-1:0] rx_q, rx_d;
  logic                   ena_q, ena_d;
  logic                   terr_q, terr_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [NREQ-1:0]        pick_win;
  logic [IW-1:0]          pick_idx;
  logic                   abort;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .last    (last_q),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

`ifdef TC_SPI_ARB_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Held at zero in IDLE so it starts clean on every entry to ARM.
  assign abort = ((state_q == ARM) || (state_q == XFER)) && (wd_q == WD_LAST);

  always_comb begin
    wd_d = wd_q;
    if (state_q == IDLE)
      wd_d = '0;
    else if ((state_q == ARM) || (state_q == XFER))
      wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      last_q  <= LAST_RST;
      rx_q    <= '0;
      ena_q   <= 1'b0;
      terr_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_d;
      done_q  <= done_d;
      last_q  <= last_d;
      rx_q    <= rx_d;
      ena_q   <= ena_d;
      terr_q  <= terr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (|bus.req) state_nxt = ARM;
      ARM: begin
        if (abort)                  state_nxt = HOLD;
        else if (!bus.spi_not_busy) state_nxt = XFER;
      end
      XFER:    if (abort || bus.spi_not_busy) state_nxt = HOLD;
      HOLD:    if (hold_q == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    ena_d   = ena_q;
    rx_d    = rx_q;
    hold_d  = hold_q;
    done_d  = '0;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = pick_win;
          last_d  = pick_idx;
          ena_d   = 1'b1;
        end
      end
      ARM: begin
        if (abort) begin
          ena_d  = 1'b0;
          terr_d = 1'b1;
          hold_d = HOLD_LOAD;
        end else if (!bus.spi_not_busy) begin
          ena_d = 1'b0;
        end
      end
      XFER: begin
        if (abort) begin
          terr_d = 1'b1;
          hold_d = HOLD_LOAD;
        end else if (bus.spi_not_busy) begin
          rx_d   = bus.spi_rx_data;
          done_d = grant_q;
          hold_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        // Counter still at its load value only on the first HOLD cycle.
        if (hold_q == HOLD_LOAD) grant_d = '0;
        if (hold_q != '0)        hold_d  = hold_q - 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.spi_cs_n    = ~grant_q;
  assign bus.done        = done_q;
  assign bus.rx_data     = rx_q;
  assign bus.spi_ena     = ena_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_tc_spi_arbiter.sv
// Bench for tc_spi_arbiter: SPI master model, owner/frame scoreboard checked on each done pulse.
module tb_tc_spi_arbiter;
  import tc_spi_pkg::*;

  localparam int NREQ    = 4;
  localparam int HOLDOFF = 16;
`ifdef TC_SPI_ARB_TIMEOUT_EN
  localparam int TIMEOUT  = 100;
  localparam int EXP_TERR = 1;
`else
  localparam int TIMEOUT  = 4095;
  localparam int EXP_TERR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tc_spi_arbiter_if #(.NREQ(NREQ)) bus ();

  tc_spi_arbiter #(.NREQ(NREQ), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // SPI master model: busy 2 cycles after spi_ena, idle again 40 cycles later with a frame.
  logic        master_stuck = 1'b0;
  logic [31:0] frame_base   = '0;
  int          frame_no     = 0;
  logic [31:0] exp_data_q[$];
  int          exp_owner_q[$];

  initial begin
    bus.spi_not_busy = 1'b1;
    bus.spi_rx_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.spi_ena && bus.spi_not_busy && !master_stuck) begin
        @(negedge clk);
        bus.spi_not_busy = 1'b0;
        repeat (40) @(negedge clk);
        bus.spi_rx_data = frame_base + 32'(frame_no);
        exp_data_q.push_back(frame_base + 32'(frame_no));
        frame_no++;
        bus.spi_not_busy = 1'b1;
      end
    end
  end

  int              n_grant = 0, grant_cyc = 0;
  int              n_done  = 0, done_cyc  = 0;
  int              n_terr  = 0, terr_cyc  = 0;
  logic [NREQ-1:0] grant_prev = '0;
  logic [NREQ-1:0] last_grant = '0;
  int              done_cnt[NREQ];

  always @(negedge clk) begin : monitor
    int owner;
    if (bus.grant != '0 && grant_prev == '0) begin
      n_grant++;
      grant_cyc  = cyc;
      last_grant = bus.grant;
    end
    grant_prev = bus.grant;
    if (bus.timeout_err) begin
      n_terr++;
      terr_cyc = cyc;
    end
    if (bus.done != '0) begin
      n_done++;
      done_cyc = cyc;
      for (int i = 0; i < NREQ; i++) if (bus.done[i]) done_cnt[i]++;
      if (exp_owner_q.size() == 0) begin
        chk("done_unexpected", 32'(bus.done), 32'h0);
      end else begin
        owner = exp_owner_q.pop_front();
        chk("done_owner", 32'(bus.done), 32'(1) << owner);
      end
      if (exp_data_q.size() == 0) chk("rx_no_frame", bus.rx_data, 32'hFFFF_FFFF);
      else                        chk("rx_data", bus.rx_data, exp_data_q.pop_front());
    end
  end

  task automatic wait_grant(input int n, input int budget);
    while (n_grant < n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk("grant_wait", 32'(n_grant >= n), 32'h1);
  endtask

  task automatic wait_done(input int n, input int budget);
    while (n_done < n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk("done_wait", 32'(n_done >= n), 32'h1);
  endtask

  task automatic wait_terr(input int n, input int budget);
    while (n_terr < n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk("terr_wait", 32'(n_terr >= n), 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
    chk({tag, "_cs_n"},  32'(bus.spi_cs_n), 32'hF);
    chk({tag, "_ena"},   32'(bus.spi_ena), 32'h0);
    chk({tag, "_done"},  32'(bus.done), 32'h0);
    chk({tag, "_rx"},    bus.rx_data, 32'h0);
    chk({tag, "_terr"},  32'(bus.timeout_err), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int g0, d0, t0, t_req, gc;
    rst     = 1'b1;
    bus.req = '0;
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Single requester
    frame_base = 32'hDEAD_BEEF;
    frame_no   = 0;
    exp_owner_q.push_back(0);
    t_req   = cyc;
    bus.req = 4'b0001;
    wait_grant(1, 10);
    chk("t1_latency", 32'(grant_cyc - t_req), 32'd1);
    chk("t1_grant", 32'(bus.grant), 32'h1);
    chk("t1_cs_n", 32'(bus.spi_cs_n), 32'hE);
    chk("t1_ena", 32'(bus.spi_ena), 32'h1);
    bus.req = '0;
    wait_done(1, 100);
    chk("t1_rx", bus.rx_data, 32'hDEAD_BEEF);
    chk("t1_grant_in_done", 32'(bus.grant), 32'h1);
    @(negedge clk); #1;
    chk("t1_grant_rel", 32'(bus.grant), 32'h0);
    chk("t1_cs_rel", 32'(bus.spi_cs_n), 32'hF);
    chk("t1_done_pulse", 32'(bus.done), 32'h0);
    repeat (HOLDOFF + 5) @(negedge clk);
    #1;

    // All requesting: rotation from reset, holdoff spacing
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    frame_base = 32'hC0DE_0000;
    frame_no   = 0;
    for (int f = 0; f < 8; f++) exp_owner_q.push_back(f % NREQ);
    g0 = n_grant;
    d0 = n_done;
    bus.req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      wait_grant(g0 + f + 1, 40);
      if (f > 0) chk("holdoff_gap", 32'(grant_cyc - done_cyc), 32'(HOLDOFF + 2));
      wait_done(d0 + f + 1, 100);
    end
    bus.req = '0;
    for (int i = 0; i < NREQ; i++) chk("done_twice", 32'(done_cnt[i]), 32'd2);
    repeat (HOLDOFF + 5) @(negedge clk);
    #1;

    // Owner drops req during XFER
    frame_base = 32'h1234_0000;
    frame_no   = 0;
    exp_owner_q.push_back(0);
    exp_owner_q.push_back(1);
    g0 = n_grant;
    d0 = n_done;
    bus.req = 4'b0101;
    wait_grant(g0 + 1, 10);
    chk("t3_first", 32'(last_grant), 32'h1);
    repeat (10) @(negedge clk);
    #1;
    chk("t3_xfer_ena", 32'(bus.spi_ena), 32'h0);
    bus.req = 4'b0110;
    wait_done(d0 + 1, 100);
    wait_grant(g0 + 2, 40);
    chk("t3_next", 32'(last_grant), 32'h2);
    bus.req = '0;
    wait_done(d0 + 2, 100);
    repeat (HOLDOFF + 5) @(negedge clk);
    #1;

    // Reset during XFER
    frame_base = 32'h5555_0000;
    g0 = n_grant;
    d0 = n_done;
    bus.req = 4'b0001;
    wait_grant(g0 + 1, 10);
    chk("t4_grant", 32'(last_grant), 32'h1);
    repeat (10) @(negedge clk);
    #1;
    bus.req = '0;
    rst     = 1'b1;
    @(negedge clk); #1;
    chk_reset_outputs("t4");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    chk("t4_no_done", 32'(n_done), 32'(d0));
    exp_data_q.delete();

`ifdef TC_SPI_ARB_TIMEOUT_EN
    // Watchdog abort with master stuck idle
    master_stuck = 1'b1;
    g0 = n_grant;
    d0 = n_done;
    t0 = n_terr;
    bus.req = 4'b0011;
    wait_grant(g0 + 1, 10);
    chk("t5_grant", 32'(last_grant), 32'h1);
    gc = grant_cyc;
    wait_terr(t0 + 1, 150);
    chk("t5_abort_delay", 32'(terr_cyc - gc), 32'(TIMEOUT));
    chk("t5_no_done", 32'(n_done), 32'(d0));
    chk("t5_rx_kept", bus.rx_data, 32'h0);
    chk("t5_ena", 32'(bus.spi_ena), 32'h0);
    master_stuck = 1'b0;
    frame_base   = 32'hABCD_0000;
    frame_no     = 0;
    exp_owner_q.push_back(1);
    wait_grant(g0 + 2, 40);
    chk("t5_next", 32'(last_grant), 32'h2);
    bus.req = '0;
    wait_done(d0 + 1, 100);
    repeat (HOLDOFF + 5) @(negedge clk);
    #1;
`endif

    chk("terr_count", 32'(n_terr), 32'(EXP_TERR));
    chk("owner_q_empty", 32'(exp_owner_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
